door_motor_sensor: RTL and testbench
====================================

# door_motor_sensor

- Models the garage door mechanism on the other side of the door controller's motor/limit-switch interface.
- Consumes the UP_M and DN_M motor commands, tracks door position with a prescaled position counter, and produces the UP_Max and DN_Max limit-switch signals.
- Flags illegal motor commands and motor overrun into a limit.
- Used as the closed-loop plant in controller benches and as the sensor-side block of the door subsystem.

## Interface

Parameters:

- POS_W, 8, width of position counter
- TRAVEL, 100, position value of fully open door (1..2^POS_W-1)
- STEP_DIV, 4, clock cycles per position step (>=2)
- OVR_LIM, 8, cycles motor may drive into a reached limit before overrun fault (>=1)
- INIT_POS, 0, position loaded at reset (0..TRAVEL)

Ports:

- CLK  input  1  clock, rising edge
- RST  input  1  reset, asynchronous, active-low
- UP_M  input  1  up-motor command
- DN_M  input  1  down-motor command
- Obstruct  input  1  mechanical obstruction; halts motion
- Fault_Clr  input  1  clears a latched fault
- UP_Max  output  1  high when Pos == TRAVEL
- DN_Max  output  1  high when Pos == 0
- Moving  output  1  high in RISE or FALL
- Fault  output  1  high in FAULT
- Fault_Code  output  2  00 none, 01 conflict, 10 overrun; sticky until cleared
- Pos  output  POS_W  current door position

## Operation

Reset (RST low, async):
- State = STOP, Pos = INIT_POS, prescaler = 0, overrun counter = 0, Fault_Code = 00.
- UP_Max and DN_Max are decodes of registered Pos. With defaults: DN_Max = 1, UP_Max = 0, Moving = 0, Fault = 0.

States: STOP, RISE, FALL, FAULT. Evaluated each edge in the priority order below.

STOP:
- UP_M & DN_M -> FAULT, code 01.
- UP_M & !Obstruct -> RISE.
- DN_M & !Obstruct -> FALL.
- Otherwise stay.

RISE:
- UP_M & DN_M -> FAULT, code 01.
- !UP_M or Obstruct -> STOP.
- Pos < TRAVEL: on a prescaler terminal edge, Pos += 1.
- Pos == TRAVEL: overrun counter += 1 each edge; FAULT (code 10) on the edge the counter reaches OVR_LIM.

FALL:
- Mirror of RISE: DN_M for UP_M, decrement toward 0, overrun counted at Pos == 0.

FAULT:
- Pos frozen; Moving = 0.
- Exit to STOP (Fault_Code -> 00) only when Fault_Clr & !UP_M & !DN_M.
- Fault_Clr while any motor command is high is ignored.

Counters:
- Prescaler and overrun counter are zeroed on every entry to RISE/FALL and whenever in STOP or FAULT.
- Pos never leaves 0..TRAVEL: no wrap-around, saturation enforced by state logic.
- Fault_Clr outside FAULT has no effect.
- Obstruct has no effect in FAULT.

## Timing

- Command sampled at edge 0 -> state changes at edge 0; Moving high after edge 0.
- Prescaler in RISE/FALL counts 0..STEP_DIV-1. A terminal edge is an edge where the prescaler equals STEP_DIV-1; Pos steps on that edge and the prescaler returns to 0.
- First Pos step is at edge STEP_DIV after entry. Full travel 0 -> TRAVEL takes TRAVEL*STEP_DIV edges after entry. UP_Max rises on that last step edge.
- A motion interrupted and restarted restarts the prescaler: a partial step is lost.
- Command release or Obstruct -> STOP at the same sampling edge; no further Pos change.
- Overrun: with Pos at a limit and the command held, FAULT asserts at the OVR_LIM-th edge after the limit was reached.
- A controller that drops the motor within OVR_LIM-1 cycles of seeing the limit never faults.
- Async reset mid-motion: Pos returns to INIT_POS immediately, independent of CLK.

## Test plan

- Reset with INIT_POS=0 -> DN_Max=1, UP_Max=0, Moving=0, Fault=0, Fault_Code=00, Pos=0.
- UP_M held from Pos=0 -> Pos=1 at edge 4, UP_Max=1 and Pos=100 at edge 400. Drop UP_M at edge 402 -> STOP, no fault.
- UP_M held 8 edges past Pos=100 -> Fault=1, Fault_Code=10, Moving=0. Fault_Clr with UP_M=1 -> stays FAULT. Fault_Clr with both motors low -> STOP, Fault_Code=00.
- UP_M=DN_M=1 in STOP, and separately in FALL at Pos=50 -> FAULT, code 01, Pos frozen (50 in the FALL case).
- FALL from Pos=100, Obstruct at edge 10 -> STOP with Pos=98. Reassert DN_M with Obstruct low -> next step 4 edges after re-entry (Pos=97).
- RST low mid-RISE at Pos=37 -> immediate Pos=0, DN_M... DN_Max=1, state STOP. After release, no motion until a command is applied.

Source files
------------

// File: rtl/door_motor_sensor.sv
// rtl/door_motor_sensor.sv - garage door plant: motor commands in, limit switches and position out
module door_motor_sensor #(
    parameter int POS_W    = 8,
    parameter int TRAVEL   = 100,
    parameter int STEP_DIV = 4,
    parameter int OVR_LIM  = 8,
    parameter int INIT_POS = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             UP_M,
    input  logic             DN_M,
    input  logic             Obstruct,
    input  logic             Fault_Clr,
    output logic             UP_Max,
    output logic             DN_Max,
    output logic             Moving,
    output logic             Fault,
    output logic [1:0]       Fault_Code,
    output logic [POS_W-1:0] Pos
);

    localparam int PW = $clog2(STEP_DIV);
    localparam int OW = $clog2(OVR_LIM + 1);

    localparam logic [PW-1:0]    PRESC_TERM = PW'(STEP_DIV - 1);
    localparam logic [OW-1:0]    OVR_TERM   = OW'(OVR_LIM);
    localparam logic [POS_W-1:0] POS_TOP    = POS_W'(TRAVEL);
    localparam logic [POS_W-1:0] POS_INIT   = POS_W'(INIT_POS);

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_CONFLICT = 2'b01;
    localparam logic [1:0] CODE_OVERRUN  = 2'b10;

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RISE,
        ST_FALL,
        ST_FAULT
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] w_pos_nx;
    logic [PW-1:0]    r_presc;
    logic [PW-1:0]    w_presc_nx;
    logic [OW-1:0]    r_ovr;
    logic [OW-1:0]    w_ovr_nx;
    logic [1:0]       r_code;
    logic [1:0]       w_code_nx;

    // State, position and counter registers; reset reloads the initial position at once
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_STOP;
            r_pos   <= POS_INIT;
            r_presc <= '0;
            r_ovr   <= '0;
            r_code  <= CODE_NONE;
        end else begin
            r_state <= w_state_nx;
            r_pos   <= w_pos_nx;
            r_presc <= w_presc_nx;
            r_ovr   <= w_ovr_nx;
            r_code  <= w_code_nx;
        end
    end

    // Next-state logic; counters default to zero so every entry to motion starts a fresh step
    always_comb begin
        w_state_nx = r_state;
        w_pos_nx   = r_pos;
        w_presc_nx = '0;
        w_ovr_nx   = '0;
        w_code_nx  = r_code;
        case (r_state)
            ST_STOP: begin
                if (UP_M && DN_M) begin
                    w_state_nx = ST_FAULT;
                    w_code_nx  = CODE_CONFLICT;
                end else if (UP_M && !Obstruct) begin
                    w_state_nx = ST_RISE;
                end else if (DN_M && !Obstruct) begin
                    w_state_nx = ST_FALL;
                end
            end
            ST_RISE: begin
                if (UP_M && DN_M) begin
                    w_state_nx = ST_FAULT;
                    w_code_nx  = CODE_CONFLICT;
                end else if (!UP_M || Obstruct) begin
                    w_state_nx = ST_STOP;
                end else if (r_pos < POS_TOP) begin
                    if (r_presc == PRESC_TERM) begin
                        w_pos_nx = r_pos + POS_W'(1);
                    end else begin
                        w_presc_nx = r_presc + PW'(1);
                    end
                end else if (r_ovr + OW'(1) == OVR_TERM) begin
                    w_state_nx = ST_FAULT;
                    w_code_nx  = CODE_OVERRUN;
                end else begin
                    w_ovr_nx = r_ovr + OW'(1);
                end
            end
            ST_FALL: begin
                if (UP_M && DN_M) begin
                    w_state_nx = ST_FAULT;
                    w_code_nx  = CODE_CONFLICT;
                end else if (!DN_M || Obstruct) begin
                    w_state_nx = ST_STOP;
                end else if (r_pos != '0) begin
                    if (r_presc == PRESC_TERM) begin
                        w_pos_nx = r_pos - POS_W'(1);
                    end else begin
                        w_presc_nx = r_presc + PW'(1);
                    end
                end else if (r_ovr + OW'(1) == OVR_TERM) begin
                    w_state_nx = ST_FAULT;
                    w_code_nx  = CODE_OVERRUN;
                end else begin
                    w_ovr_nx = r_ovr + OW'(1);
                end
            end
            ST_FAULT: begin
                if (Fault_Clr && !UP_M && !DN_M) begin
                    w_state_nx = ST_STOP;
                    w_code_nx  = CODE_NONE;
                end
            end
            default: begin
                w_state_nx = ST_STOP;
            end
        endcase
    end

    assign UP_Max     = (r_pos == POS_TOP);
    assign DN_Max     = (r_pos == '0);
    assign Moving     = (r_state == ST_RISE) || (r_state == ST_FALL);
    assign Fault      = (r_state == ST_FAULT);
    assign Fault_Code = r_code;
    assign Pos        = r_pos;

endmodule

// File: tb/tb_door_motor_sensor.sv
// tb/tb_door_motor_sensor.sv - self-checking bench for door_motor_sensor
module tb_door_motor_sensor;

    localparam int POS_W    = 8;
    localparam int TRAVEL   = 100;
    localparam int STEP_DIV = 4;
    localparam int OVR_LIM  = 8;
    localparam int INIT_POS = 0;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             UP_M = 1'b0;
    logic             DN_M = 1'b0;
    logic             Obstruct = 1'b0;
    logic             Fault_Clr = 1'b0;
    logic             UP_Max;
    logic             DN_Max;
    logic             Moving;
    logic             Fault;
    logic [1:0]       Fault_Code;
    logic [POS_W-1:0] Pos;

    int n_vec = 0;
    int n_err = 0;

    door_motor_sensor #(
        .POS_W(POS_W), .TRAVEL(TRAVEL), .STEP_DIV(STEP_DIV),
        .OVR_LIM(OVR_LIM), .INIT_POS(INIT_POS)
    ) dut (
        .CLK(CLK), .RST(RST), .UP_M(UP_M), .DN_M(DN_M),
        .Obstruct(Obstruct), .Fault_Clr(Fault_Clr),
        .UP_Max(UP_Max), .DN_Max(DN_Max), .Moving(Moving),
        .Fault(Fault), .Fault_Code(Fault_Code), .Pos(Pos)
    );

    always #5 CLK = ~CLK;

    // Model: motion is described by the position at entry and the edges elapsed since entry.
    // Mode 0 idle, 1 raising, 2 lowering, 3 faulted.
    int m_mode = 0;
    int m_pos = INIT_POS;
    int m_start = INIT_POS;
    int m_t = 0;
    int m_code = 0;

    function automatic void model_next(
        input int mode, input int pos, input int start, input int t, input int code,
        input bit up, input bit dn, input bit ob, input bit clr,
        output int n_mode, output int n_pos, output int n_start, output int n_t, output int n_code);
        int need;
        n_mode = mode; n_pos = pos; n_start = start; n_t = t; n_code = code;
        if (mode == 3) begin
            if (clr && !up && !dn) begin n_mode = 0; n_code = 0; end
        end else if (up && dn) begin
            n_mode = 3; n_code = 1;
        end else if (mode == 0) begin
            if (up && !ob)      begin n_mode = 1; n_start = pos; n_t = 0; end
            else if (dn && !ob) begin n_mode = 2; n_start = pos; n_t = 0; end
        end else if ((mode == 1 && !up) || (mode == 2 && !dn) || ob) begin
            n_mode = 0;
        end else begin
            n_t = t + 1;
            need = (mode == 1) ? (TRAVEL - start) * STEP_DIV : start * STEP_DIV;
            if (n_t <= need)
                n_pos = (mode == 1) ? start + n_t / STEP_DIV : start - n_t / STEP_DIV;
            else if (n_t - need >= OVR_LIM) begin
                n_mode = 3; n_code = 2;
            end
        end
    endfunction

    // Advance the model on every edge and on asynchronous reset
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_mode <= 0; m_pos <= INIT_POS; m_start <= INIT_POS; m_t <= 0; m_code <= 0;
        end else begin
            int a, b, c, d, e;
            model_next(m_mode, m_pos, m_start, m_t, m_code, UP_M, DN_M, Obstruct, Fault_Clr,
                       a, b, c, d, e);
            m_mode <= a; m_pos <= b; m_start <= c; m_t <= d; m_code <= e;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model shortly after each edge
    always @(posedge CLK) begin
        #1;
        chk("pos",      int'(Pos),        m_pos);
        chk("up_max",   int'(UP_Max),     int'(m_pos == TRAVEL));
        chk("dn_max",   int'(DN_Max),     int'(m_pos == 0));
        chk("moving",   int'(Moving),     int'(m_mode == 1 || m_mode == 2));
        chk("fault",    int'(Fault),      int'(m_mode == 3));
        chk("code",     int'(Fault_Code), m_code);
    end

    task automatic edges(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        #3;
        chk("rst_dn_max", int'(DN_Max), 1);
        chk("rst_up_max", int'(UP_Max), 0);
        chk("rst_moving", int'(Moving), 0);
        chk("rst_fault",  int'(Fault), 0);
        chk("rst_code",   int'(Fault_Code), 0);
        chk("rst_pos",    int'(Pos), 0);
        edges(2);
        RST = 1'b1;
        edges(1);

        // Full rise from 0
        UP_M = 1'b1;
        edges(4);
        chk("rise_pos_e3", int'(Pos), 0);
        chk("rise_moving", int'(Moving), 1);
        edges(1);
        chk("rise_pos_e4", int'(Pos), 1);
        edges(395);
        chk("rise_pos_e399", int'(Pos), 99);
        chk("rise_upmax_e399", int'(UP_Max), 0);
        edges(1);
        chk("rise_pos_e400", int'(Pos), 100);
        chk("rise_upmax_e400", int'(UP_Max), 1);
        edges(1);
        UP_M = 1'b0;
        edges(1);
        chk("drop_moving", int'(Moving), 0);
        chk("drop_fault", int'(Fault), 0);
        chk("drop_pos", int'(Pos), 100);

        // Overrun into the top limit
        UP_M = 1'b1;
        edges(8);
        chk("ovr_fault_e7", int'(Fault), 0);
        edges(1);
        chk("ovr_fault_e8", int'(Fault), 1);
        chk("ovr_code", int'(Fault_Code), 2);
        chk("ovr_moving", int'(Moving), 0);
        Fault_Clr = 1'b1;
        edges(2);
        chk("clr_ignored", int'(Fault), 1);
        UP_M = 1'b0;
        edges(1);
        chk("clr_fault", int'(Fault), 0);
        chk("clr_code", int'(Fault_Code), 0);
        Fault_Clr = 1'b0;

        // Conflict in STOP
        UP_M = 1'b1; DN_M = 1'b1;
        edges(1);
        chk("conf_stop_fault", int'(Fault), 1);
        chk("conf_stop_code", int'(Fault_Code), 1);
        chk("conf_stop_pos", int'(Pos), 100);
        UP_M = 1'b0; DN_M = 1'b0; Fault_Clr = 1'b1;
        edges(1);
        Fault_Clr = 1'b0;

        // Fall to 50, then conflict
        DN_M = 1'b1;
        edges(201);
        chk("fall_pos50", int'(Pos), 50);
        UP_M = 1'b1;
        edges(6);
        chk("conf_fall_code", int'(Fault_Code), 1);
        chk("conf_fall_pos", int'(Pos), 50);
        UP_M = 1'b0; DN_M = 1'b0; Fault_Clr = 1'b1;
        edges(1);
        Fault_Clr = 1'b0;

        // Back to the top, then obstructed fall
        UP_M = 1'b1;
        edges(201);
        chk("rerise_pos", int'(Pos), 100);
        UP_M = 1'b0;
        edges(1);
        DN_M = 1'b1;
        edges(10);
        chk("obs_pre_pos", int'(Pos), 98);
        Obstruct = 1'b1;
        edges(1);
        chk("obs_moving", int'(Moving), 0);
        chk("obs_pos", int'(Pos), 98);
        edges(3);
        chk("obs_hold_pos", int'(Pos), 98);
        Obstruct = 1'b0;
        edges(4);
        chk("restart_pos_e3", int'(Pos), 98);
        edges(1);
        chk("restart_pos_e4", int'(Pos), 97);
        DN_M = 1'b0;
        edges(1);

        // Async reset mid-rise at 37
        RST = 1'b0;
        edges(1);
        RST = 1'b1;
        edges(1);
        UP_M = 1'b1;
        edges(149);
        chk("mid_rise_pos", int'(Pos), 37);
        #2;
        RST = 1'b0;
        #1;
        chk("async_pos", int'(Pos), 0);
        chk("async_dn_max", int'(DN_Max), 1);
        chk("async_moving", int'(Moving), 0);
        UP_M = 1'b0;
        edges(2);
        RST = 1'b1;
        edges(10);
        chk("post_rst_pos", int'(Pos), 0);
        chk("post_rst_moving", int'(Moving), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
